mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have one clock (clk) and a synchronous, active-high reset (rst); no other clock or reset.
REQ-003 SHALL have EX-side inputs: valid_i 1; mem_op_i 4 (0 none, 1 LD.B, 2 LD.BU, 3 LD.H, 4 LD.HU, 5 LD.W, 6 ST.B, 7 ST.H, 8 ST.W, 9-15 treated as none); result_i 32 (ALU result / effective address); result2_i 32 (store data / second result); destination_i 5; destination2_i 5; PSW_i 32; PC_i 25.
REQ-004 SHALL have stall_o  out  1; high tells EX to hold all inputs.
REQ-005 SHALL have data-bus ports: dmem_req_o out 1; dmem_we_o out 1; dmem_addr_o out 32; dmem_wdata_o out 32; dmem_be_o out 4; dmem_ack_i in 1; dmem_rdata_i in 32.
REQ-006 SHALL have WB-side outputs: valid_o 1; result_o 32; result2_o 32; destination_o 5; destination2_o 5; PSW_o 32; PC_o 25; misalign_o 1; bus_error_o 1.
REQ-007 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of ACCESS cycles without dmem_ack_i.

Function
REQ-008 SHALL implement FSM states IDLE and ACCESS; stall_o = (state==ACCESS).
REQ-009 In IDLE, valid_i=1 with a none op SHALL register all payload to the WB outputs with valid_o=1 on the next cycle (latency 1).
REQ-010 In IDLE, valid_i=0 SHALL set valid_o=0 on the next cycle; the other WB outputs hold their previous values.
REQ-011 In IDLE, a memory op SHALL check alignment: H needs addr[0]=0, W needs addr[1:0]=0.
REQ-012 A misaligned op SHALL issue no bus request; next cycle valid_o=1, misalign_o=1 (one cycle), destination_o=0, destination2_o=0; the FSM stays in IDLE.
REQ-013 An aligned memory op SHALL latch the payload, enter ACCESS, and clear the timeout counter.
REQ-014 In ACCESS: dmem_req_o=1, dmem_addr_o=result_i latched, dmem_we_o=1 for ST ops only.
REQ-015 Byte enables SHALL be little-endian: B gives 4'b0001<<addr[1:0]; H gives 4'b0011<<addr[1:0]; W gives 4'b1111.
REQ-016 dmem_wdata_o SHALL replicate the byte to all 4 lanes (B), the halfword to both halves (H), or pass the word unchanged (W).
REQ-017 Outside ACCESS, dmem_req_o, dmem_we_o and dmem_be_o SHALL be 0.
REQ-018 When dmem_ack_i=1 in ACCESS, the next cycle SHALL have state IDLE, valid_o=1, and stall_o=0; a new instruction is accepted in that cycle.
REQ-019 On a load ack, result_o SHALL be the selected lane, sign-extended (LD.B, LD.H) or zero-extended (LD.BU, LD.HU), or the full word (LD.W); destination_o = latched destination_i.
REQ-020 On a store ack, result_o = latched address and destination_o = 0 (no GR write).
REQ-021 For all ops, result2_o, destination2_o, PSW_o and PC_o SHALL pass through from the latched values.
REQ-022 A minimum load/store SHALL take 2 cycles: accept, then ACCESS with ack in the same cycle; valid_o follows on the next cycle.
REQ-023 The counter SHALL increment every ACCESS cycle without ack; if it reaches TIMEOUT, the next cycle has bus_error_o=1 (one cycle), valid_o=1, destination_o=0, destination2_o=0, state IDLE.
REQ-024 An ack in the same cycle the counter reaches TIMEOUT SHALL win: normal completion, no bus_error_o.
REQ-025 dmem_ack_i in IDLE SHALL be ignored.
REQ-026 valid_i SHALL be ignored while in ACCESS.
REQ-027 misalign_o and bus_error_o SHALL be 0 except for their one-cycle pulses.

Reset
REQ-028 On rst=1 at a clk edge: state IDLE; counter 0; all outputs 0, including valid_o, stall_o, dmem_req_o, misalign_o, bus_error_o and all data outputs.
REQ-029 Reset during ACCESS SHALL drop dmem_req_o on the following cycle; the in-flight op is discarded; an ack arriving after reset is ignored.
REQ-030 valid_i asserted in the same cycle as rst=1 SHALL be discarded.

Verification
REQ-031 ALU pass-through: mem_op_i=0, result_i=0x12345678, destination_i=5 -> next cycle valid_o=1, result_o=0x12345678, destination_o=5, stall_o=0.
REQ-032 LD.B: address 0x1003, ack after 3 wait cycles, rdata=0x80FFFFFF -> dmem_be_o=0001... shifted to 1000, stall_o high 4 cycles, result_o=0xFFFFFF80, destination_o latched.
REQ-033 ST.H: address 0x2002, result2_i=0x0000ABCD, immediate ack -> dmem_be_o=1100, dmem_wdata_o=0xABCDABCD, dmem_we_o=1, destination_o=0.
REQ-034 LD.W at address 0x3001 -> no dmem_req_o; misalign_o=1 for 1 cycle, valid_o=1, destination_o=0.
REQ-035 LD.HU at 0x4000, no ack -> bus_error_o after TIMEOUT cycles, dmem_req_o drops, stall_o drops; repeat with ack exactly at TIMEOUT -> normal completion.
REQ-036 Reset asserted on the 2nd ACCESS cycle, then a late ack -> outputs 0, state IDLE, ack ignored, next instruction processed normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory-access pipeline stage between EX and WB. Non-memory ops pass
// straight through with one cycle of latency. Loads and stores are checked
// for alignment, then held in ACCESS while the data bus request is
// outstanding. EX is stalled for as long as the request is held. A missing
// ack turns into a bus-error completion after TIMEOUT cycles.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   valid_i, mem_op_i, result_i,  EX-side instruction payload
//   result2_i, destination_i,
//   destination2_i, PSW_i, PC_i
//   stall_o                       EX must hold its outputs while high
//   dmem_*                        data bus (req/we/addr/wdata/be, ack/rdata)
//   valid_o ... PC_o              WB-side registered payload
//   misalign_o, bus_error_o       one-cycle exception pulses alongside valid_o
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] result_i,
  input  logic [31:0] result2_i,
  input  logic [4:0]  destination_i,
  input  logic [4:0]  destination2_i,
  input  logic [31:0] PSW_i,
  input  logic [24:0] PC_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [31:0] result2_o,
  output logic [4:0]  destination_o,
  output logic [4:0]  destination2_o,
  output logic [31:0] PSW_o,
  output logic [24:0] PC_o,
  output logic        misalign_o,
  output logic        bus_error_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  // Access size: 0 none, 1 byte, 2 halfword, 3 word
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: op_size = 2'd1;
      4'd3, 4'd4, 4'd7: op_size = 2'd2;
      4'd5, 4'd8:       op_size = 2'd3;
      default:          op_size = 2'd0;
    endcase
  endfunction

  function automatic logic op_store(input logic [3:0] op);
    op_store = (op == 4'd6) || (op == 4'd7) || (op == 4'd8);
  endfunction

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;

  // Instruction captured on entry to ACCESS
  logic [3:0]     op_reg, op_next;
  logic [31:0]    addr_reg, addr_next;
  logic [31:0]    data_reg, data_next;
  logic [4:0]     dst_reg, dst_next;
  logic [4:0]     dst2_reg, dst2_next;
  logic [31:0]    psw_reg, psw_next;
  logic [24:0]    pc_reg, pc_next;

  // WB-side output registers
  logic           valid_reg, valid_next;
  logic [31:0]    res_reg, res_next;
  logic [31:0]    res2_reg, res2_next;
  logic [4:0]     wdst_reg, wdst_next;
  logic [4:0]     wdst2_reg, wdst2_next;
  logic [31:0]    wpsw_reg, wpsw_next;
  logic [24:0]    wpc_reg, wpc_next;
  logic           mis_reg, mis_next;
  logic           berr_reg, berr_next;

  logic [1:0]     size_in, size_reg;
  logic           misaligned_in;
  logic           access;
  logic [7:0]     lane_b;
  logic [15:0]    lane_h;
  logic [31:0]    load_val;

  assign size_in       = op_size(mem_op_i);
  assign size_reg      = op_size(op_reg);
  assign misaligned_in = ((size_in == 2'd2) && result_i[0]) ||
                         ((size_in == 2'd3) && (result_i[1:0] != 2'b00));
  assign access        = (state_reg == ACCESS);

  // Little-endian lane extraction for loads
  assign lane_b = dmem_rdata_i[{addr_reg[1:0], 3'b000} +: 8];
  assign lane_h = dmem_rdata_i[{addr_reg[1], 4'b0000} +: 16];

  always_comb begin
    case (op_reg)
      4'd1:    load_val = {{24{lane_b[7]}}, lane_b};
      4'd2:    load_val = {24'd0, lane_b};
      4'd3:    load_val = {{16{lane_h[15]}}, lane_h};
      4'd4:    load_val = {16'd0, lane_h};
      default: load_val = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    dst_next   = dst_reg;
    dst2_next  = dst2_reg;
    psw_next   = psw_reg;
    pc_next    = pc_reg;
    valid_next = 1'b0;
    res_next   = res_reg;
    res2_next  = res2_reg;
    wdst_next  = wdst_reg;
    wdst2_next = wdst2_reg;
    wpsw_next  = wpsw_reg;
    wpc_next   = wpc_reg;
    mis_next   = 1'b0;
    berr_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          if (size_in == 2'd0 || misaligned_in) begin
            // Completes immediately; a misaligned op suppresses both writes
            valid_next = 1'b1;
            res_next   = result_i;
            res2_next  = result2_i;
            wpsw_next  = PSW_i;
            wpc_next   = PC_i;
            mis_next   = misaligned_in;
            wdst_next  = misaligned_in ? 5'd0 : destination_i;
            wdst2_next = misaligned_in ? 5'd0 : destination2_i;
          end else begin
            state_next = ACCESS;
            cnt_next   = '0;
            op_next    = mem_op_i;
            addr_next  = result_i;
            data_next  = result2_i;
            dst_next   = destination_i;
            dst2_next  = destination2_i;
            psw_next   = PSW_i;
            pc_next    = PC_i;
          end
        end
      end
      ACCESS: begin
        if (dmem_ack_i || cnt_reg == LAST_COUNT) begin
          // An ack on the final allowed cycle takes priority over timeout
          state_next = IDLE;
          valid_next = 1'b1;
          res2_next  = data_reg;
          wpsw_next  = psw_reg;
          wpc_next   = pc_reg;
          if (dmem_ack_i) begin
            res_next   = op_store(op_reg) ? addr_reg : load_val;
            wdst_next  = op_store(op_reg) ? 5'd0 : dst_reg;
            wdst2_next = dst2_reg;
          end else begin
            berr_next  = 1'b1;
            res_next   = addr_reg;
            wdst_next  = 5'd0;
            wdst2_next = 5'd0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      dst_reg   <= '0;
      dst2_reg  <= '0;
      psw_reg   <= '0;
      pc_reg    <= '0;
      valid_reg <= 1'b0;
      res_reg   <= '0;
      res2_reg  <= '0;
      wdst_reg  <= '0;
      wdst2_reg <= '0;
      wpsw_reg  <= '0;
      wpc_reg   <= '0;
      mis_reg   <= 1'b0;
      berr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      dst_reg   <= dst_next;
      dst2_reg  <= dst2_next;
      psw_reg   <= psw_next;
      pc_reg    <= pc_next;
      valid_reg <= valid_next;
      res_reg   <= res_next;
      res2_reg  <= res2_next;
      wdst_reg  <= wdst_next;
      wdst2_reg <= wdst2_next;
      wpsw_reg  <= wpsw_next;
      wpc_reg   <= wpc_next;
      mis_reg   <= mis_next;
      berr_reg  <= berr_next;
    end
  end

  // Bus side is driven only while a request is outstanding
  always_comb begin
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = 32'd0;
    if (access) begin
      case (size_reg)
        2'd1: begin
          dmem_be_o    = 4'b0001 << addr_reg[1:0];
          dmem_wdata_o = {4{data_reg[7:0]}};
        end
        2'd2: begin
          dmem_be_o    = 4'b0011 << addr_reg[1:0];
          dmem_wdata_o = {2{data_reg[15:0]}};
        end
        default: begin
          dmem_be_o    = 4'b1111;
          dmem_wdata_o = data_reg;
        end
      endcase
    end
  end

  assign stall_o        = access;
  assign dmem_req_o     = access;
  assign dmem_we_o      = access && op_store(op_reg);
  assign dmem_addr_o    = access ? addr_reg : 32'd0;

  assign valid_o        = valid_reg;
  assign result_o       = res_reg;
  assign result2_o      = res2_reg;
  assign destination_o  = wdst_reg;
  assign destination2_o = wdst2_reg;
  assign PSW_o          = wpsw_reg;
  assign PC_o           = wpc_reg;
  assign misalign_o     = mis_reg;
  assign bus_error_o    = berr_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed stimulus with a scoreboard queue
// of expected WB transactions, checked by an independent monitor.
module tb_mem_access_stage;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [3:0]  mem_op_i;
  logic [31:0] result_i, result2_i;
  logic [4:0]  destination_i, destination2_i;
  logic [31:0] PSW_i;
  logic [24:0] PC_i;
  logic        stall_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o;
  logic [31:0] result_o, result2_o;
  logic [4:0]  destination_o, destination2_o;
  logic [31:0] PSW_o;
  logic [24:0] PC_o;
  logic        misalign_o, bus_error_o;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .mem_op_i(mem_op_i), .result_i(result_i),
    .result2_i(result2_i), .destination_i(destination_i),
    .destination2_i(destination2_i), .PSW_i(PSW_i), .PC_i(PC_i),
    .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_o(valid_o), .result_o(result_o), .result2_o(result2_o),
    .destination_o(destination_o), .destination2_o(destination2_o),
    .PSW_o(PSW_o), .PC_o(PC_o), .misalign_o(misalign_o),
    .bus_error_o(bus_error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [31:0] result2;
    logic [4:0]  dst;
    logic [4:0]  dst2;
    logic [31:0] psw;
    logic [24:0] pc;
    logic        mis;
    logic        berr;
    logic        full;   // compare result/result2/psw/pc as well
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   txn    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per valid_o cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(valid_o), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d: result=%h dst=%0d dst2=%0d mis=%0b berr=%0b",
                   txn, result_o, destination_o, destination2_o, misalign_o, bus_error_o);
          check("misalign_o", 32'(misalign_o), 32'(e.mis));
          check("bus_error_o", 32'(bus_error_o), 32'(e.berr));
          check("destination_o", 32'(destination_o), 32'(e.dst));
          check("destination2_o", 32'(destination2_o), 32'(e.dst2));
          if (e.full) begin
            check("result_o", result_o, e.result);
            check("result2_o", result2_o, e.result2);
            check("PSW_o", PSW_o, e.psw);
            check("PC_o", 32'(PC_o), 32'(e.pc));
          end
        end
      end else begin
        check("idle_pulses", {30'd0, misalign_o, bus_error_o}, 32'd0);
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] res, input logic [31:0] res2,
                       input logic [4:0] dst, input logic [4:0] dst2);
    valid_i        = 1'b1;
    mem_op_i       = op;
    result_i       = res;
    result2_i      = res2;
    destination_i  = dst;
    destination2_i = dst2;
    PSW_i          = res ^ 32'h5A5A_0000;
    PC_i           = res2[24:0] ^ 25'h0ABCDE;
  endtask

  task automatic push(input logic [31:0] res, input logic [31:0] res2, input logic [4:0] dst,
                      input logic [4:0] dst2, input logic mis, input logic berr, input logic full);
    exp_t e;
    e.result = res;  e.result2 = res2; e.dst = dst; e.dst2 = dst2;
    e.psw = PSW_i;   e.pc = PC_i;      e.mis = mis; e.berr = berr; e.full = full;
    exp_q.push_back(e);
  endtask

  // Single-cycle instruction (ALU pass-through or misaligned)
  task automatic do_simple(input logic [3:0] op, input logic [31:0] res, input logic [31:0] res2,
                           input logic [4:0] dst, input logic [4:0] dst2, input logic mis);
    drive(op, res, res2, dst, dst2);
    if (mis) push(res, res2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    else     push(res, res2, dst, dst2, 1'b0, 1'b0, 1'b1);
    tick();
    valid_i = 1'b0;
    check("simple_stall", 32'(stall_o), 32'd0);
    check("simple_req", 32'(dmem_req_o), 32'd0);
  endtask

  // Memory op acked after 'waits' non-ack ACCESS cycles
  task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] dst, input logic [4:0] dst2, input int waits,
                        input logic [31:0] rdata, input logic [31:0] exp_res, input logic [4:0] exp_dst,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata, input logic exp_we);
    drive(op, addr, data, dst, dst2);
    push(exp_res, data, exp_dst, dst2, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i <= waits; i++) begin
      // Junk on the EX side while stalled must be ignored
      valid_i  = (i != waits);
      mem_op_i = 4'd0;
      if (i == waits) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
      end
      check("acc_stall", 32'(stall_o), 32'd1);
      check("acc_req", 32'(dmem_req_o), 32'd1);
      check("acc_we", 32'(dmem_we_o), 32'(exp_we));
      check("acc_be", 32'(dmem_be_o), 32'(exp_be));
      check("acc_addr", dmem_addr_o, addr);
      if (exp_we) check("acc_wdata", dmem_wdata_o, exp_wdata);
      tick();
      dmem_ack_i = 1'b0;
    end
    check("done_stall", 32'(stall_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
    drive(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd3, 5'd4);   // discarded under reset
    repeat (3) tick();
    rst = 1'b0; valid_i = 1'b0;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_req", 32'(dmem_req_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_dst", 32'(destination_o), 32'd0);
    check("rst_pulses", {30'd0, misalign_o, bus_error_o}, 32'd0);
    tick();

    // ALU pass-through
    do_simple(4'd0, 32'h1234_5678, 32'h0000_0042, 5'd5, 5'd6, 1'b0);
    // Op codes 9-15 behave as none
    do_simple(4'd12, 32'hA000_0001, 32'h0000_0007, 5'd8, 5'd9, 1'b0);

    // LD.B, 3 wait cycles, top lane sign-extended
    do_mem(4'd1, 32'h0000_1003, 32'd0, 5'd7, 5'd2, 3, 32'h80FF_FFFF,
           32'hFFFF_FF80, 5'd7, 4'b1000, 32'd0, 1'b0);
    // ST.H immediate ack
    do_mem(4'd7, 32'h0000_2002, 32'h0000_ABCD, 5'd9, 5'd1, 0, 32'd0,
           32'h0000_2002, 5'd0, 4'b1100, 32'hABCD_ABCD, 1'b1);
    // LD.BU lane 1
    do_mem(4'd2, 32'h0000_5001, 32'd0, 5'd10, 5'd0, 1, 32'h0000_F000,
           32'h0000_00F0, 5'd10, 4'b0010, 32'd0, 1'b0);
    // LD.H upper half sign-extended
    do_mem(4'd3, 32'h0000_4002, 32'd0, 5'd11, 5'd0, 0, 32'h8001_0000,
           32'hFFFF_8001, 5'd11, 4'b1100, 32'd0, 1'b0);
    // ST.B lane 2
    do_mem(4'd6, 32'h0000_6002, 32'h0000_00A5, 5'd12, 5'd13, 0, 32'd0,
           32'h0000_6002, 5'd0, 4'b0100, 32'hA5A5_A5A5, 1'b1);
    // ST.W
    do_mem(4'd8, 32'h0000_7000, 32'hDEAD_BEEF, 5'd14, 5'd0, 2, 32'd0,
           32'h0000_7000, 5'd0, 4'b1111, 32'hDEAD_BEEF, 1'b1);
    // LD.W
    do_mem(4'd5, 32'h0000_8004, 32'd0, 5'd15, 5'd16, 0, 32'hCAFE_F00D,
           32'hCAFE_F00D, 5'd15, 4'b1111, 32'd0, 1'b0);

    // Misaligned LD.W and ST.H
    do_simple(4'd5, 32'h0000_3001, 32'd0, 5'd17, 5'd18, 1'b1);
    do_simple(4'd7, 32'h0000_3003, 32'h1111, 5'd19, 5'd20, 1'b1);

    // Ack in IDLE must not produce anything
    dmem_ack_i = 1'b1;
    tick();
    dmem_ack_i = 1'b0;
    tick();

    // LD.HU timeout: TO ACCESS cycles with no ack
    drive(4'd4, 32'h0000_4000, 32'd0, 5'd21, 5'd22);
    push(32'h0000_4000, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < TO; i++) begin
      check("to_req", 32'(dmem_req_o), 32'd1);
      tick();
    end
    check("to_req_drop", 32'(dmem_req_o), 32'd0);
    check("to_stall_drop", 32'(stall_o), 32'd0);
    tick();

    // Ack on the final allowed cycle wins over timeout
    do_mem(4'd4, 32'h0000_4000, 32'd0, 5'd23, 5'd24, TO - 1, 32'h0000_8001,
           32'h0000_8001, 5'd23, 4'b0011, 32'd0, 1'b0);

    // Reset on the 2nd ACCESS cycle, then a late ack
    drive(4'd5, 32'h0000_9000, 32'd0, 5'd25, 5'd26);
    tick();
    valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_req", 32'(dmem_req_o), 32'd0);
    check("rst2_stall", 32'(stall_o), 32'd0);
    check("rst2_valid", 32'(valid_o), 32'd0);
    check("rst2_result", result_o, 32'd0);
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'hBAD0_BAD0;
    tick();
    dmem_ack_i = 1'b0;
    check("late_ack_req", 32'(dmem_req_o), 32'd0);
    do_simple(4'd0, 32'h0BAD_CAFE, 32'h0000_0099, 5'd27, 5'd28, 1'b0);

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
